// File: rtl/tournament_table_arbiter_if.sv
// Bus bundle for tournament_table_arbiter: prediction read port, update port
// and the single-port 2-bit-counter table port.
// master: the requester/table side; slave: the arbiter.
interface tournament_table_arbiter_if #(
  parameter int idx_width_p = 10
);
  logic                   r_v_i;
  logic [idx_width_p-1:0] idx_r_i;
  logic                   r_ready_o;
  logic                   predict_v_o;
  logic                   predict_o;
  logic                   w_v_i;
  logic [idx_width_p-1:0] idx_w_i;
  logic                   taken_i;
  logic                   w_ready_o;
  logic                   tbl_v_o;
  logic                   tbl_w_o;
  logic [idx_width_p-1:0] tbl_idx_o;
  logic [1:0]             tbl_data_o;
  logic [1:0]             tbl_data_i;

  modport master (
    output r_v_i, idx_r_i, w_v_i, idx_w_i, taken_i, tbl_data_i,
    input  r_ready_o, predict_v_o, predict_o, w_ready_o,
           tbl_v_o, tbl_w_o, tbl_idx_o, tbl_data_o
  );

  modport slave (
    input  r_v_i, idx_r_i, w_v_i, idx_w_i, taken_i, tbl_data_i,
    output r_ready_o, predict_v_o, predict_o, w_ready_o,
           tbl_v_o, tbl_w_o, tbl_idx_o, tbl_data_o
  );
endinterface

// File: rtl/tournament_table_arbiter.sv
// Arbitrates a single-port 2-bit saturating-counter table between prediction
// reads and queued read-modify-write updates from resolved branches.
// Optional build macro: TOURN_ARB_STARVE_EN adds a starvation counter that
// forces a pending update after starve_limit_p consecutive read grants.
//
// state     | meaning
// ST_IDLE   | reads served; update granted when queue non-empty and allowed
// ST_UPD_RD | table read data for the head update captured; no table access
// ST_UPD_WR | saturated counter written back, queue head popped
module tournament_table_arbiter #(
  parameter int idx_width_p    = 10,
  parameter int fifo_depth_p   = 4,
  parameter int starve_limit_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  tournament_table_arbiter_if.slave        bus
);

  localparam int ptr_w = $clog2(fifo_depth_p);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPD_RD = 2'd1,
    ST_UPD_WR = 2'd2
  } state_t;

  state_t                 r_state;
  logic [1:0]             r_cnt;
  logic                   r_pred_v;

  logic [idx_width_p-1:0] r_fifo_idx [fifo_depth_p];
  logic                   r_fifo_tkn [fifo_depth_p];
  logic [ptr_w:0]         r_wr_ptr;
  logic [ptr_w:0]         r_rd_ptr;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic [idx_width_p-1:0] w_head_idx;
  logic                   w_head_tkn;
  logic                   w_idle;
  logic                   w_starved;
  logic                   w_upd_grant;
  logic                   w_rd_grant;
  logic [1:0]             w_cnt_new;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[ptr_w] != r_rd_ptr[ptr_w]) &&
                      (r_wr_ptr[ptr_w-1:0] == r_rd_ptr[ptr_w-1:0]);
  assign w_push     = bus.w_v_i && !w_full;
  assign w_pop      = (r_state == ST_UPD_WR);
  assign w_head_idx = r_fifo_idx[r_rd_ptr[ptr_w-1:0]];
  assign w_head_tkn = r_fifo_tkn[r_rd_ptr[ptr_w-1:0]];

  // No table traffic at all while held in reset, even if r_v_i is high.
  assign w_idle      = (r_state == ST_IDLE) && reset_n_i;
  assign w_upd_grant = w_idle && !w_empty && (!bus.r_v_i || w_full || w_starved);
  assign w_rd_grant  = w_idle && bus.r_v_i && !w_upd_grant;

`ifdef TOURN_ARB_STARVE_EN
  localparam int starve_w = $clog2(starve_limit_p + 1);
  logic [starve_w-1:0] r_starve_cnt;

  assign w_starved = (r_starve_cnt == starve_w'(starve_limit_p));

  // Count read grants that bypass a waiting update; saturate at the limit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_starve_cnt <= '0;
    end else if (w_empty || w_upd_grant) begin
      r_starve_cnt <= '0;
    end else if (w_rd_grant && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + starve_w'(1);
    end
  end
`else
  // Starvation relief compiled out; the limit has no effect (never negative).
  assign w_starved = (starve_limit_p < 0);
`endif

  // Queue pointers; storage below is reset-free since it is gated by them.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{ptr_w{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{ptr_w{1'b0}}, 1'b1};
    end
  end

  // Update queue storage.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr[ptr_w-1:0]] <= bus.idx_w_i;
      r_fifo_tkn[r_wr_ptr[ptr_w-1:0]] <= bus.taken_i;
    end
  end

  // Update sequencer plus the one-cycle prediction-valid flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 2'd0;
      r_pred_v <= 1'b0;
    end else begin
      r_pred_v <= w_rd_grant;
      case (r_state)
        ST_IDLE: begin
          if (w_upd_grant) r_state <= ST_UPD_RD;
        end
        ST_UPD_RD: begin
          r_cnt   <= bus.tbl_data_i;
          r_state <= ST_UPD_WR;
        end
        ST_UPD_WR: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating counter step for the head update.
  always_comb begin
    w_cnt_new = r_cnt;
    if (w_head_tkn) begin
      if (r_cnt != 2'd3) w_cnt_new = r_cnt + 2'd1;
    end else begin
      if (r_cnt != 2'd0) w_cnt_new = r_cnt - 2'd1;
    end
  end

  // Table port drive: read for a prediction, read for an update, or write-back.
  always_comb begin
    bus.tbl_v_o    = 1'b0;
    bus.tbl_w_o    = 1'b0;
    bus.tbl_idx_o  = '0;
    bus.tbl_data_o = 2'd0;
    if (w_rd_grant) begin
      bus.tbl_v_o   = 1'b1;
      bus.tbl_idx_o = bus.idx_r_i;
    end else if (w_upd_grant) begin
      bus.tbl_v_o   = 1'b1;
      bus.tbl_idx_o = w_head_idx;
    end else if (r_state == ST_UPD_WR) begin
      bus.tbl_v_o    = 1'b1;
      bus.tbl_w_o    = 1'b1;
      bus.tbl_idx_o  = w_head_idx;
      bus.tbl_data_o = w_cnt_new;
    end
  end

  assign bus.r_ready_o   = w_rd_grant;
  assign bus.w_ready_o   = !w_full;
  assign bus.predict_v_o = r_pred_v;
  assign bus.predict_o   = r_pred_v & bus.tbl_data_i[1];

endmodule

// File: tb/tb_tournament_table_arbiter.sv
// Directed bench for tournament_table_arbiter with a behavioural table model.
module tb_tournament_table_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   n_wr;
  int   n0;
  logic [1:0] mem [1024];
  logic [1:0] rdata;

  tournament_table_arbiter_if #(.idx_width_p(10)) bus ();

  tournament_table_arbiter #(
    .idx_width_p(10),
    .fifo_depth_p(4),
    .starve_limit_p(8)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.tbl_data_i = rdata;

  // Synchronous single-port table model.
  always @(posedge clk) begin
    if (bus.tbl_v_o) begin
      if (bus.tbl_w_o) begin
        mem[bus.tbl_idx_o] <= bus.tbl_data_o;
        n_wr <= n_wr + 1;
      end else begin
        rdata <= mem[bus.tbl_idx_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run_update(input logic [9:0] idx, input logic tkn, input logic [1:0] exp_d);
    @(negedge clk);
    bus.r_v_i = 1'b0; bus.w_v_i = 1'b1; bus.idx_w_i = idx; bus.taken_i = tkn;
    #1;
    chk("upd_wready", bus.w_ready_o, 1);
    @(negedge clk);
    bus.w_v_i = 1'b0;
    #1;
    chk("upd_grant_v", bus.tbl_v_o, 1);
    chk("upd_grant_w", bus.tbl_w_o, 0);
    chk("upd_grant_idx", bus.tbl_idx_o, idx);
    chk("upd_grant_rready", bus.r_ready_o, 0);
    @(negedge clk); #1;
    chk("upd_rd_quiet", bus.tbl_v_o, 0);
    @(negedge clk); #1;
    chk("upd_wr_v", bus.tbl_v_o, 1);
    chk("upd_wr_w", bus.tbl_w_o, 1);
    chk("upd_wr_idx", bus.tbl_idx_o, idx);
    chk("upd_wr_data", bus.tbl_data_o, exp_d);
    @(negedge clk); #1;
    chk("upd_done_v", bus.tbl_v_o, 0);
    chk("upd_done_data", bus.tbl_data_o, 0);
  endtask

  task automatic do_read(input logic [9:0] idx, input logic exp_p);
    @(negedge clk);
    bus.r_v_i = 1'b1; bus.idx_r_i = idx;
    #1;
    chk("rd_ready", bus.r_ready_o, 1);
    chk("rd_tbl_v", bus.tbl_v_o, 1);
    chk("rd_tbl_w", bus.tbl_w_o, 0);
    chk("rd_tbl_idx", bus.tbl_idx_o, idx);
    @(negedge clk);
    bus.r_v_i = 1'b0;
    #1;
    chk("rd_pred_v", bus.predict_v_o, 1);
    chk("rd_pred", bus.predict_o, exp_p);
    @(negedge clk); #1;
    chk("rd_pred_v_off", bus.predict_v_o, 0);
    chk("rd_pred_off", bus.predict_o, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_wr = 0;
    rdata = 2'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 2'd0;
    rst_n = 1'b0;
    bus.r_v_i = 1'b0; bus.idx_r_i = '0;
    bus.w_v_i = 1'b0; bus.idx_w_i = '0; bus.taken_i = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_wready", bus.w_ready_o, 1);
    chk("rst_tbl_v", bus.tbl_v_o, 0);
    chk("rst_rready", bus.r_ready_o, 0);
    chk("rst_pred_v", bus.predict_v_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_rready", bus.r_ready_o, 0);
    chk("post_rst_tbl_v", bus.tbl_v_o, 0);

    // Single updates with saturation at both ends
    mem[5] = 2'd3;
    run_update(10'd5, 1'b1, 2'd3);
    mem[7] = 2'd0;
    run_update(10'd7, 1'b0, 2'd0);
    mem[7] = 2'd2;
    run_update(10'd7, 1'b0, 2'd1);
    mem[3] = 2'd1;
    run_update(10'd3, 1'b1, 2'd2);
    chk("mem7_after", mem[7], 1);
    chk("mem3_after", mem[3], 2);

    // Predictions
    mem[9] = 2'd2;
    do_read(10'd9, 1'b1);
    mem[9] = 2'd1;
    do_read(10'd9, 1'b0);

    // Fill the queue under continuous reads; stale reads of idx 9
    mem[21] = 2'd1; mem[22] = 2'd2; mem[23] = 2'd3;
    n0 = n_wr;
    @(negedge clk);
    bus.r_v_i = 1'b1; bus.idx_r_i = 10'd9;
    bus.w_v_i = 1'b1; bus.idx_w_i = 10'd9; bus.taken_i = 1'b1;
    #1;
    chk("q_rd0_ready", bus.r_ready_o, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      bus.idx_w_i = 10'(20 + k);
      #1;
      chk("q_rd_ready", bus.r_ready_o, 1);
      chk("q_wready", bus.w_ready_o, 1);
      chk("q_stale_pv", bus.predict_v_o, 1);
      chk("q_stale_p", bus.predict_o, 0);
    end
    @(negedge clk);
    bus.w_v_i = 1'b0;
    #1;
    chk("q_full_wready", bus.w_ready_o, 0);
    chk("q_full_grant_rready", bus.r_ready_o, 0);
    chk("q_full_grant_v", bus.tbl_v_o, 1);
    chk("q_full_grant_w", bus.tbl_w_o, 0);
    chk("q_full_grant_idx", bus.tbl_idx_o, 9);
    chk("q_full_stale_p", bus.predict_o, 0);
    @(negedge clk); #1;
    chk("q_updrd_rready", bus.r_ready_o, 0);
    chk("q_updrd_v", bus.tbl_v_o, 0);
    chk("q_updrd_pv", bus.predict_v_o, 0);
    @(negedge clk); #1;
    chk("q_updwr_w", bus.tbl_w_o, 1);
    chk("q_updwr_idx", bus.tbl_idx_o, 9);
    chk("q_updwr_data", bus.tbl_data_o, 2);
    chk("q_updwr_wready", bus.w_ready_o, 0);
    chk("q_updwr_rready", bus.r_ready_o, 0);
    @(negedge clk); #1;
    chk("q_pop_wready", bus.w_ready_o, 1);
    chk("q_pop_rready", bus.r_ready_o, 1);
    bus.r_v_i = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    chk("q_drain_writes", n_wr, n0 + 4);
    chk("q_mem9", mem[9], 2);
    chk("q_mem21", mem[21], 2);
    chk("q_mem22", mem[22], 3);
    chk("q_mem23", mem[23], 3);

    // Reads held high with one pending update
    mem[30] = 2'd0;
    n0 = n_wr;
    @(negedge clk);
    bus.r_v_i = 1'b1; bus.idx_r_i = 10'd9;
    bus.w_v_i = 1'b1; bus.idx_w_i = 10'd30; bus.taken_i = 1'b1;
    #1;
    chk("sv_rd0_ready", bus.r_ready_o, 1);
`ifdef TOURN_ARB_STARVE_EN
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.w_v_i = 1'b0;
      #1;
      chk("sv_rd_ready", bus.r_ready_o, 1);
    end
    @(negedge clk); #1;
    chk("sv_forced_rready", bus.r_ready_o, 0);
    chk("sv_forced_idx", bus.tbl_idx_o, 30);
    @(negedge clk); #1;
    chk("sv_updrd_rready", bus.r_ready_o, 0);
    @(negedge clk); #1;
    chk("sv_updwr_rready", bus.r_ready_o, 0);
    chk("sv_updwr_w", bus.tbl_w_o, 1);
    chk("sv_updwr_data", bus.tbl_data_o, 1);
    @(negedge clk); #1;
    chk("sv_resume_rready", bus.r_ready_o, 1);
`else
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.w_v_i = 1'b0;
      #1;
      chk("sv_rd_ready", bus.r_ready_o, 1);
    end
    chk("sv_no_write", n_wr, n0);
    @(negedge clk);
    bus.r_v_i = 1'b0;
    #1;
    chk("sv_drop_grant_v", bus.tbl_v_o, 1);
    chk("sv_drop_grant_idx", bus.tbl_idx_o, 30);
`endif
    bus.r_v_i = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("sv_writes", n_wr, n0 + 1);
    chk("sv_mem30", mem[30], 1);

    // Reset during write-back with a full queue
    for (int i = 40; i < 44; i++) mem[i] = 2'd2;
    n0 = n_wr;
    @(negedge clk);
    bus.r_v_i = 1'b1; bus.idx_r_i = 10'd9;
    bus.w_v_i = 1'b1; bus.idx_w_i = 10'd40; bus.taken_i = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      bus.idx_w_i = 10'(40 + k);
    end
    @(negedge clk);
    bus.w_v_i = 1'b0;
    #1;
    chk("rr_grant_idx", bus.tbl_idx_o, 40);
    @(negedge clk);
    @(negedge clk); #1;
    chk("rr_pre_wr", bus.tbl_w_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_in_rst_tbl_v", bus.tbl_v_o, 0);
    chk("rr_in_rst_wready", bus.w_ready_o, 1);
    chk("rr_in_rst_rready", bus.r_ready_o, 0);
    chk("rr_in_rst_pv", bus.predict_v_o, 0);
    @(negedge clk);
    bus.r_v_i = 1'b0;
    #1;
    chk("rr_in_rst_tbl_v2", bus.tbl_v_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk("rr_after_tbl_v", bus.tbl_v_o, 0);
    end
    chk("rr_after_wready", bus.w_ready_o, 1);
    chk("rr_no_write", n_wr, n0);
    chk("rr_mem40", mem[40], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tournament_table_arbiter.md
TOURNAMENT_TABLE_ARBITER -- requirements
Module: tournament_table_arbiter

Interface
REQ-001 SHALL have parameter idx_width_p, default 10, table index width.
REQ-002 SHALL have parameter fifo_depth_p, default 4, update-queue entries (power of 2, >=2).
REQ-003 SHALL have parameter starve_limit_p, default 8, read-grant cycles before a pending update is forced.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port r_v_i  input  1  prediction read request.
REQ-007 SHALL have port idx_r_i  input  idx_width_p  prediction read index.
REQ-008 SHALL have port r_ready_o  output  1  read accepted this cycle.
REQ-009 SHALL have port predict_v_o  output  1  prediction valid.
REQ-010 SHALL have port predict_o  output  1  predicted taken.
REQ-011 SHALL have port w_v_i  input  1  resolved-branch update request.
REQ-012 SHALL have port idx_w_i  input  idx_width_p  update index.
REQ-013 SHALL have port taken_i  input  1  resolved direction.
REQ-014 SHALL have port w_ready_o  output  1  update queue can accept.
REQ-015 SHALL have ports tbl_v_o (out 1), tbl_w_o (out 1), tbl_idx_o (out idx_width_p), tbl_data_o (out 2), tbl_data_i (in 2): single-port 2-bit-counter table, synchronous read, data on tbl_data_i one cycle after read issue.

Function
REQ-016 SHALL queue updates in a FIFO; push when w_v_i && w_ready_o; w_ready_o = !full; no same-cycle push-when-full.
REQ-017 SHALL run FSM IDLE -> UPD_RD -> UPD_WR -> IDLE for each update.
REQ-018 In IDLE, SHALL grant update (tbl_v_o=1, tbl_w_o=0, tbl_idx_o=FIFO head idx, go UPD_RD) when FIFO non-empty and (r_v_i=0 or FIFO full or starve count = starve_limit_p).
REQ-019 Otherwise in IDLE with r_v_i=1, SHALL set r_ready_o=1, tbl_v_o=1, tbl_w_o=0, tbl_idx_o=idx_r_i, combinationally.
REQ-020 r_ready_o SHALL be 0 in UPD_RD, UPD_WR, and in IDLE when update granted.
REQ-021 predict_v_o SHALL be 1 exactly the cycle after a read acceptance; predict_o = tbl_data_i[1] then, else 0.
REQ-022 UPD_RD SHALL register tbl_data_i and issue no table access.
REQ-023 UPD_WR SHALL drive tbl_v_o=1, tbl_w_o=1, head idx, tbl_data_o = taken ? min(c+1,3) : max(c-1,0); SHALL pop FIFO; return IDLE.
REQ-024 Starve counter SHALL increment (saturating at starve_limit_p) each IDLE cycle a read is granted while FIFO non-empty; clear to 0 on update grant or FIFO empty.
REQ-025 Read to an index with a pending update SHALL return the stale table value (no forwarding).
REQ-026 tbl_v_o SHALL be 0 when no access is issued; tbl_data_o SHALL be 0 unless writing.

Reset
REQ-027 reset_n_i low SHALL immediately clear FIFO (empty), starve counter, FSM to IDLE, predict_v_o=0; in-flight and queued updates discarded.
REQ-028 After reset: r_ready_o=0 until r_v_i, w_ready_o=1, tbl_v_o=0.

Configuration
REQ-029 Macro TOURN_ARB_STARVE_EN: defined -> REQ-018 starve clause and REQ-024 counter present; undefined -> counter absent, updates granted only when r_v_i=0 or FIFO full.

Verification
REQ-030 Reset mid-UPD_WR with 3 queued -> tbl_v_o=0 during reset, w_ready_o=1, no write after release.
REQ-031 r_v_i=0, one update idx=5 taken, table[5]=3 -> read idx 5, one idle cycle, write 3 (saturated), 3-cycle occupancy.
REQ-032 Update idx=7 not-taken, table[7]=0 -> write 0; table[7]=2 -> write 1.
REQ-033 r_v_i held 1, one update queued (TOURN_ARB_STARVE_EN) -> 8 reads granted, then update forced, r_ready_o=0 for 3 cycles; without macro -> update never issues until r_v_i drops.
REQ-034 4 updates pushed back-to-back with r_v_i=1 -> w_ready_o=0 after 4th, update granted next IDLE, w_ready_o=1 after UPD_WR pop.
REQ-035 Read idx=9, table[9]=2 -> predict_v_o=1, predict_o=1 next cycle; table[9]=1 -> predict_o=0.
